// File: rtl/ara_pkg.sv
// Shared types for the lane VRF write path: instruction ids, element data, and
// the registered write bundle handed from the FU result arbiter to the VRF bank.
package ara_pkg;

  localparam int unsigned NrVInsn      = 8;
  localparam int unsigned ELEN         = 64;
  // Widest VRF element address carried in the write bundle; narrower vaddr_t
  // values are zero-extended into it.
  localparam int unsigned VrfAddrWidth = 16;

  typedef logic [$clog2(NrVInsn)-1:0] vid_t;
  typedef logic [ELEN-1:0]            elen_t;
  typedef logic [ELEN/8-1:0]          elen_strb_t;
  typedef logic [VrfAddrWidth-1:0]    vrf_addr_t;

  typedef enum logic {
    WrSrcAlu  = 1'b0,
    WrSrcMfpu = 1'b1
  } wr_src_e;

  typedef struct packed {
    vid_t       id;
    vrf_addr_t  addr;
    elen_t      wdata;
    elen_strb_t be;
    wr_src_e    src;
  } vrf_wr_req_t;

endpackage

// File: rtl/rr_arb_2.sv
// Two-way round-robin arbiter: bit 0 = ALU, bit 1 = MFPU. When both request,
// the one not granted last wins; the pointer only moves on an actual grant.
module rr_arb_2
  import ara_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  wr_src_e last_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[0] && (!req_i[1] || last_q == WrSrcMfpu)) gnt_o[0] = 1'b1;
      else if (req_i[1])                                   gnt_o[1] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       last_q <= WrSrcMfpu;  // makes the ALU win the first tie
    else if (|gnt_o) last_q <= gnt_o[1] ? WrSrcMfpu : WrSrcAlu;
  end

endmodule

// File: rtl/vfu_result_wr_arbiter.sv
// Per-lane VRF write-port arbiter between the vector ALU and MFPU result paths,
// with a one-entry registered output stage. Optional perf counters: VFU_RESULT_ARB_PERF_CNT_EN.
module vfu_result_wr_arbiter
  import ara_pkg::*;
#(
  parameter  int unsigned NrLanes   = 0,
  parameter  type         vaddr_t   = logic,
  localparam int unsigned DataWidth = $bits(elen_t),
  localparam type         strb_t    = logic [DataWidth/8-1:0]
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alu_req_i,
  input  vid_t                 alu_id_i,
  input  vaddr_t               alu_addr_i,
  input  logic [DataWidth-1:0] alu_wdata_i,
  input  strb_t                alu_be_i,
  output logic                 alu_gnt_o,
  input  logic                 mfpu_req_i,
  input  vid_t                 mfpu_id_i,
  input  vaddr_t               mfpu_addr_i,
  input  logic [DataWidth-1:0] mfpu_wdata_i,
  input  strb_t                mfpu_be_i,
  output logic                 mfpu_gnt_o,
  output logic                 vrf_req_o,
  output vid_t                 vrf_id_o,
  output vaddr_t               vrf_addr_o,
  output logic [DataWidth-1:0] vrf_wdata_o,
  output strb_t                vrf_be_o,
  output logic                 vrf_src_o,
  input  logic                 vrf_gnt_i
`ifdef VFU_RESULT_ARB_PERF_CNT_EN
  ,
  output logic [31:0]          alu_wr_cnt_o,
  output logic [31:0]          mfpu_wr_cnt_o,
  output logic [31:0]          stall_cnt_o
`endif
);

  vrf_wr_req_t stage_q, stage_d;
  logic        valid_q;
  logic        stage_free;
  logic [1:0]  gnt;

  // A draining write frees the stage in the same cycle, so a refill costs no bubble.
  assign stage_free = !valid_q || vrf_gnt_i;

  rr_arb_2 i_rr_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i ({mfpu_req_i, alu_req_i}),
    .en_i  (stage_free),
    .gnt_o (gnt)
  );

  assign alu_gnt_o  = gnt[0];
  assign mfpu_gnt_o = gnt[1];

  always_comb begin
    stage_d = stage_q;
    if (gnt[0]) begin
      stage_d = '{id: alu_id_i, addr: vrf_addr_t'(alu_addr_i), wdata: alu_wdata_i,
                  be: alu_be_i, src: WrSrcAlu};
    end else if (gnt[1]) begin
      stage_d = '{id: mfpu_id_i, addr: vrf_addr_t'(mfpu_addr_i), wdata: mfpu_wdata_i,
                  be: mfpu_be_i, src: WrSrcMfpu};
    end
  end

  // NOTE: the stage payload is reset along with its valid bit because the
  // bundle is visible on the ports and must read 0 out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else begin
      valid_q <= (|gnt) || (valid_q && !vrf_gnt_i);
      stage_q <= stage_d;
    end
  end

  assign vrf_req_o   = valid_q;
  assign vrf_id_o    = stage_q.id;
  assign vrf_addr_o  = vaddr_t'(stage_q.addr);
  assign vrf_wdata_o = stage_q.wdata;
  assign vrf_be_o    = stage_q.be;
  assign vrf_src_o   = stage_q.src;

`ifdef VFU_RESULT_ARB_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_wr_cnt_o  <= '0;
      mfpu_wr_cnt_o <= '0;
      stall_cnt_o   <= '0;
    end else begin
      if (gnt[0]) alu_wr_cnt_o  <= alu_wr_cnt_o + 32'd1;
      if (gnt[1]) mfpu_wr_cnt_o <= mfpu_wr_cnt_o + 32'd1;
      if ((alu_req_i || mfpu_req_i) && !(|gnt)) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vfu_result_wr_arbiter.sv
// Scoreboard bench for vfu_result_wr_arbiter: a cycle-level model of the grant
// rules predicts each grant and queues the expected VRF write; a monitor checks writes.
module tb_vfu_result_wr_arbiter;
  import ara_pkg::*;

  typedef struct packed {
    logic [2:0]  id;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        src;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_req, mfpu_req, alu_gnt, mfpu_gnt;
  vid_t        alu_id, mfpu_id, vrf_id;
  logic [7:0]  alu_addr, mfpu_addr, vrf_addr;
  logic [63:0] alu_wdata, mfpu_wdata, vrf_wdata;
  logic [7:0]  alu_be, mfpu_be, vrf_be;
  logic        vrf_req, vrf_src, vrf_gnt;
`ifdef VFU_RESULT_ARB_PERF_CNT_EN
  logic [31:0] alu_wr_cnt, mfpu_wr_cnt, stall_cnt;
`endif

  vfu_result_wr_arbiter #(.NrLanes(4), .vaddr_t(logic [7:0])) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .alu_req_i    (alu_req),
    .alu_id_i     (alu_id),
    .alu_addr_i   (alu_addr),
    .alu_wdata_i  (alu_wdata),
    .alu_be_i     (alu_be),
    .alu_gnt_o    (alu_gnt),
    .mfpu_req_i   (mfpu_req),
    .mfpu_id_i    (mfpu_id),
    .mfpu_addr_i  (mfpu_addr),
    .mfpu_wdata_i (mfpu_wdata),
    .mfpu_be_i    (mfpu_be),
    .mfpu_gnt_o   (mfpu_gnt),
    .vrf_req_o    (vrf_req),
    .vrf_id_o     (vrf_id),
    .vrf_addr_o   (vrf_addr),
    .vrf_wdata_o  (vrf_wdata),
    .vrf_be_o     (vrf_be),
    .vrf_src_o    (vrf_src),
    .vrf_gnt_i    (vrf_gnt)
`ifdef VFU_RESULT_ARB_PERF_CNT_EN
    ,
    .alu_wr_cnt_o  (alu_wr_cnt),
    .mfpu_wr_cnt_o (mfpu_wr_cnt),
    .stall_cnt_o   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  // Reference model state: stage occupancy and who won the last grant.
  bit          m_occ, m_last_alu, g_alu, g_mfpu;
  logic [31:0] m_alu_cnt, m_mfpu_cnt, m_stall_cnt;

  // Stimulus knobs: request probabilities (%), VRF accept mode 0=random 1=always 2=never.
  int          p_alu, p_mfpu, vmode;
  bit          force_be;
  logic [7:0]  alu_addr_ctr;
  int          dut_gnt_seen;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: predict grants from the current inputs, check them, update model.
  task automatic step();
    bit free, ea, em;
    @(negedge clk);
    free = !m_occ || vrf_gnt;
    ea   = free && alu_req && (!mfpu_req || !m_last_alu);
    em   = free && mfpu_req && !ea;
    check("alu_gnt", 128'(alu_gnt), 128'(ea));
    check("mfpu_gnt", 128'(mfpu_gnt), 128'(em));
    check("vrf_req", 128'(vrf_req), 128'(m_occ));
    dut_gnt_seen += int'(alu_gnt) + int'(mfpu_gnt);
    if (ea) begin
      exp_q.push_back('{id: alu_id, addr: alu_addr, wdata: alu_wdata, be: alu_be, src: 1'b0});
      m_last_alu = 1'b1;
      m_alu_cnt++;
    end
    if (em) begin
      exp_q.push_back('{id: mfpu_id, addr: mfpu_addr, wdata: mfpu_wdata, be: mfpu_be, src: 1'b1});
      m_last_alu = 1'b0;
      m_mfpu_cnt++;
    end
    if ((alu_req || mfpu_req) && !ea && !em) m_stall_cnt++;
    m_occ  = ea || em || (m_occ && !vrf_gnt);
    g_alu  = ea;
    g_mfpu = em;
    @(posedge clk);
    #1;
  endtask

  // Requesters hold a request until granted, then may issue a new one.
  task automatic drive();
    if (alu_req && g_alu) alu_req = 1'b0;
    if (mfpu_req && g_mfpu) mfpu_req = 1'b0;
    g_alu  = 1'b0;
    g_mfpu = 1'b0;
    if (!alu_req && $urandom_range(99) < p_alu) begin
      alu_req   = 1'b1;
      alu_id    = 3'd2;
      alu_addr  = alu_addr_ctr;
      alu_addr_ctr++;
      alu_wdata = {$urandom, $urandom};
      alu_be    = 8'($urandom);
    end
    if (!mfpu_req && $urandom_range(99) < p_mfpu) begin
      mfpu_req   = 1'b1;
      mfpu_id    = 3'($urandom);
      mfpu_addr  = 8'($urandom);
      mfpu_wdata = {$urandom, $urandom};
      mfpu_be    = force_be ? 8'hF0 : 8'($urandom);
    end
    case (vmode)
      1:       vrf_gnt = 1'b1;
      2:       vrf_gnt = 1'b0;
      default: vrf_gnt = ($urandom_range(99) < 70);
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      drive();
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    alu_req  = 1'b0;
    mfpu_req = 1'b0;
    vrf_gnt  = 1'b0;
    exp_q.delete();
    m_occ = 1'b0; m_last_alu = 1'b0; g_alu = 1'b0; g_mfpu = 1'b0;
    m_alu_cnt = '0; m_mfpu_cnt = '0; m_stall_cnt = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every cycle the stage holds a write, it must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && vrf_req) begin
      if (exp_q.size() == 0) begin
        check("vrf_unexpected_write", 128'(vrf_req), 128'(0));
      end else begin
        check("vrf_bundle", 128'({vrf_id, vrf_addr, vrf_wdata, vrf_be, vrf_src}), 128'(exp_q[0]));
        if (vrf_gnt) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    alu_id = '0; alu_addr = '0; alu_wdata = '0; alu_be = '0;
    mfpu_id = '0; mfpu_addr = '0; mfpu_wdata = '0; mfpu_be = '0;
    force_be = 1'b0; alu_addr_ctr = '0; dut_gnt_seen = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Contention: both always requesting, VRF always accepting -> alternating grants.
    p_alu = 100; p_mfpu = 100; vmode = 1;
    drive();
    run(12);

    // Empty the stage, then backpressure with both requesting: exactly one grant.
    p_alu = 0; p_mfpu = 0; vmode = 1;
    run(4);
    p_alu = 100; p_mfpu = 100; vmode = 2;
    drive();
    dut_gnt_seen = 0;
    run(5);
    check("backpressure_grants", 128'(dut_gnt_seen), 128'(1));

    // Reset with the stage full, then a lone ALU write to 0x10.
    do_reset();
    @(negedge clk);
    check("rst_vrf_req", 128'(vrf_req), 128'(0));
`ifdef VFU_RESULT_ARB_PERF_CNT_EN
    check("rst_alu_cnt", 128'(alu_wr_cnt), 128'(0));
    check("rst_mfpu_cnt", 128'(mfpu_wr_cnt), 128'(0));
    check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
`endif
    @(posedge clk);
    #1;
    p_alu = 0; p_mfpu = 0; vmode = 1;
    drive();
    alu_req = 1'b1; alu_id = 3'd2; alu_addr = 8'h10;
    alu_wdata = 64'hDEAD_BEEF_0000_0010; alu_be = 8'hFF;
    run(3);

    // Drain+refill: MFPU back-to-back with be=0xF0, VRF always accepting.
    p_mfpu = 100; force_be = 1'b1;
    drive();
    run(8);
    force_be = 1'b0;

    // Ordering: ALU addresses 0.. interleaved with MFPU under random backpressure.
    alu_addr_ctr = '0; p_alu = 100; p_mfpu = 50; vmode = 0;
    run(40);

    // Broad random traffic.
    p_alu = 60; p_mfpu = 60; vmode = 0;
    run(400);

    // Drain everything and confirm nothing is left outstanding.
    p_alu = 0; p_mfpu = 0; vmode = 1;
    drive();
    run(6);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
`ifdef VFU_RESULT_ARB_PERF_CNT_EN
    check("alu_wr_cnt", 128'(alu_wr_cnt), 128'(m_alu_cnt));
    check("mfpu_wr_cnt", 128'(mfpu_wr_cnt), 128'(m_mfpu_cnt));
    check("stall_cnt", 128'(stall_cnt), 128'(m_stall_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
